// File: rtl/cpc_mem_pkg.sv
// Shared SDRAM segment map for the boot download and upload paths; pure combinational helpers.
// Keeping one lookup here guarantees both directions agree on the 16 KB segment-to-page layout.
package cpc_mem_pkg;

  localparam int SEG_SHIFT = 14;

  localparam logic [8:0] PAGE_0 = 9'h000;
  localparam logic [8:0] PAGE_1 = 9'h100;
  localparam logic [8:0] PAGE_2 = 9'h107;
  localparam logic [8:0] PAGE_3 = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READY
  } upl_state_e;

  typedef struct packed {
    logic [8:0] page;
    logic       bank;
  } seg_map_t;

  // Segments 0-3 live in bank 0, 4-7 mirror the same page set in bank 1.
  function automatic seg_map_t seg_map(input logic [10:0] seg);
    seg_map_t m;
    m.bank = seg[2];
    case (seg[1:0])
      2'd0:    m.page = PAGE_0;
      2'd1:    m.page = PAGE_1;
      2'd2:    m.page = PAGE_2;
      default: m.page = PAGE_3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_uploader.sv
// Streams banked SDRAM bytes to the host upload port; ack-to-data 1 cycle, rd-to-req 1 cycle.
// Host is held off with ioctl_wait until a byte is latched; missing acks time out to 8'hFF.
module mem_uploader
  import cpc_mem_pkg::*;
#(
  parameter int MAX_SEG = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  output logic        mem_bank,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ack,
  output logic        err,
  output logic        done
);

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [25:0] LIMIT    = 26'(MAX_SEG * 16384);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  upl_state_e      state_q, state_d;
  logic [24:0]     cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      din_q, din_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            upl_q;

  logic            upl_rise;
  logic            past_end;
  seg_map_t        map;

  assign upl_rise = ioctl_upload & ~upl_q;
  assign past_end = {1'b0, cnt_q} >= LIMIT;
  assign map      = seg_map(cnt_q[24:SEG_SHIFT]);

  assign mem_addr   = {map.page, cnt_q[SEG_SHIFT-1:0]};
  assign mem_bank   = map.bank;
  // Gated by the live upload level so a dropped session releases the port immediately.
  assign mem_req    = (state_q == FETCH) && ioctl_upload && !past_end;
  assign ioctl_wait = (state_q != READY);
  assign ioctl_din  = din_q;
  assign err        = err_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = '0;
    din_d   = din_q;
    err_d   = err_q;
    done_d  = done_q;

    if (!ioctl_upload) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (upl_rise) begin
            cnt_d   = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (past_end) begin
            din_d   = 8'hFF;
            done_d  = 1'b1;
            state_d = READY;
          end else if (mem_ack) begin
            din_d   = mem_dout;
            state_d = READY;
          end else if (timer_q == TMO_LAST) begin
            din_d   = 8'hFF;
            err_d   = 1'b1;
            state_d = READY;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        READY: begin
          if (ioctl_rd) begin
            cnt_d   = cnt_q + 25'd1;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      din_q   <= 8'hFF;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      upl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      din_q   <= din_d;
      err_q   <= err_d;
      done_q  <= done_d;
      upl_q   <= ioctl_upload;
    end
  end

endmodule

// File: doc/mem_uploader.md
Name: mem_uploader

Overview:
- Reader counterpart of the ROM/boot download path: streams banked SDRAM contents (ROM pages, MF2 page, RAM) back to the host over the ioctl upload interface.
- Uses the same 16 KB segment-to-page map as the download path, so an uploaded image round-trips byte-exact.
- Sits between mist_io (upload side) and the SDRAM arbiter mux, which grants it the port while reset/upload is active.

Parameters:
- MAX_SEG, 8: number of 16 KB segments served; bytes beyond MAX_SEG*16384 read as 8'hFF with no memory access.
- TIMEOUT, 64: clk_sys cycles to wait for mem_ack before substituting 8'hFF.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  host upload session active (level).
- ioctl_rd  in  1  one-cycle strobe: host consumed ioctl_din; advance to next byte.
- ioctl_din  out  8  byte at current stream address.
- ioctl_wait  out  1  high while ioctl_din is not yet valid; the host must not strobe.
- mem_req  out  1  memory read request (level, held until ack).
- mem_addr  out  23  SDRAM byte address {page[8:0], offset[13:0]}.
- mem_bank  out  1  SDRAM bank.
- mem_dout  in  8  memory read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  one-cycle acknowledge.
- err  out  1  sticky: at least one fetch timed out this session.
- done  out  1  stream address has passed MAX_SEG*16384.

Behaviour:
- Reset values: ioctl_din=8'hFF, ioctl_wait=1, mem_req=0, mem_addr=0, mem_bank=0, err=0, done=0, state=IDLE, stream address cnt[24:0]=0, timer=0.
- Address map, combinational from cnt:
  - seg=cnt[24:14] → page: 0,4→9'h000; 1,5→9'h100; 2,6→9'h107; 3,7→9'h1FF.
  - mem_bank = 1 for seg 4..7, else 0. mem_addr = {page, cnt[13:0]}.
- State machine:
  - IDLE: ioctl_wait=1. On rising edge of ioctl_upload: cnt←0, err←0, done←0, go to FETCH.
  - FETCH: mem_req=1, timer counts up from 0.
    - mem_ack → ioctl_din←mem_dout, mem_req←0, go to READY (data visible the cycle after ack).
    - timer reaches TIMEOUT-1 with no ack → ioctl_din←8'hFF, err←1, go to READY.
    - mem_ack and timeout in the same cycle: ack wins, err unchanged.
    - If cnt ≥ MAX_SEG*16384 on entry: no request, ioctl_din←8'hFF, done←1, go to READY.
  - READY: ioctl_wait=0. On ioctl_rd: cnt←cnt+1, ioctl_wait←1 in the next cycle, go to FETCH.
  - ioctl_rd outside READY is ignored. No counter change, no error.
- Latency: ioctl_rd to next mem_req = 1 cycle. mem_ack to ioctl_wait low = 1 cycle.
- cnt wraps at 2^25 to 0. Stream still reports done, because bytes past the limit return FF.
- ioctl_upload falling in any state: go to IDLE next cycle, drop mem_req immediately (combinationally gated), keep ioctl_din, err, done.
  - An ack arriving after the drop is ignored.
- ioctl_upload rising again restarts from cnt=0.
- Asynchronous reset mid-fetch: all outputs return to reset values at once. The arbiter tolerates an abandoned request.

Decomposition:
- Shared package (cpc_mem_pkg): the segment→page/bank lookup function and page constants 9'h000, 9'h100, 9'h107, 9'h1FF.
  - The boot download decoder uses the same function, so both directions stay consistent.
- Also in the package: state enum {IDLE, FETCH, READY}.
- No sub-module. The timeout counter is inline.

Test Plan:
- Upload with a memory model of fixed 3-cycle ack latency, pattern byte = addr[7:0]^page[7:0]. Read 16 bytes → ioctl_din sequence matches the pattern; mem_addr[22:14]=9'h000, bank 0; err=0.
- Set cnt across the 16383→16384 boundary → mem_addr jumps to 9'h100<<14. At cnt=65536 → page 000, bank 1.
- Memory model never acks at one address → after 64 cycles ioctl_din=FF, err=1. Next byte fetches normally; err stays 1.
- MAX_SEG=1: read byte 16384 → no mem_req asserted, ioctl_din=FF, done=1.
- Drop ioctl_upload during FETCH → mem_req low the same cycle, state IDLE. A late ack leaves ioctl_din unchanged. Re-raising ioctl_upload fetches address 0.
- Assert reset asynchronously mid-FETCH → mem_req=0, ioctl_wait=1, ioctl_din=FF before the next clock edge.
- ioctl_rd pulses while ioctl_wait=1 → counter unchanged; byte order intact.
